// File: rtl/cv32e40p_pkg.sv
// Shared cv32e40p types.
// obi_arb_id_e is the requester ID recorded by the instruction OBI arbiter.
package cv32e40p_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    AUX   = 1'b1
  } obi_arb_id_e;

endpackage

// File: rtl/cv32e40p_obi_arb_order_queue.sv
// In-order FIFO of requester IDs for granted-but-unanswered OBI transactions.
// A push and a pop in the same cycle leave the count unchanged.
module cv32e40p_obi_arb_order_queue
  import cv32e40p_pkg::*;
#(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  obi_arb_id_e      push_id,
  input  logic             pop,
  output obi_arb_id_e      head_id,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [DEPTH-1:0] id_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_en;
  logic             pop_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign head_id = obi_arb_id_e'(id_q[rd_ptr_q]);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) begin
        id_q[wr_ptr_q] <= push_id;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_en && !pop_en) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop_en && !push_en) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-port instruction OBI arbiter: prefetch fetch port and aux metadata fetcher
// share one master port, with starvation protection and in-order response routing.
module cv32e40p_instr_obi_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        fetch_req_i,
  output logic        fetch_gnt_o,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_rvalid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        fetch_err_o,

  input  logic        aux_req_i,
  output logic        aux_gnt_o,
  input  logic [31:0] aux_addr_i,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  output logic        aux_err_o,

  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  input  logic        instr_err_i,

  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic                lock_q;
  obi_arb_id_e         lock_id_q;
  obi_arb_id_e         unlocked_id;
  obi_arb_id_e         sel_id;
  obi_arb_id_e         head_id;
  logic [CNT_W-1:0]    q_count;
  logic                q_empty;
  logic                q_full;
  logic                starving;
  logic                accept;
  logic                pop;

  assign starving = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    unlocked_id = FETCH;
    if (aux_req_i && (!fetch_req_i || starving)) begin
      unlocked_id = AUX;
    end
  end

  // A stalled request keeps its winner until accepted (OBI address stability).
  assign sel_id       = lock_q ? lock_id_q : unlocked_id;
  assign instr_req_o  = (fetch_req_i | aux_req_i) & ~q_full;
  assign instr_addr_o = (sel_id == AUX) ? aux_addr_i : fetch_addr_i;
  assign accept       = instr_req_o & instr_gnt_i;
  assign fetch_gnt_o  = accept & (sel_id == FETCH);
  assign aux_gnt_o    = accept & (sel_id == AUX);

  assign pop            = instr_rvalid_i & ~q_empty;
  assign fetch_rvalid_o = pop & (head_id == FETCH);
  assign aux_rvalid_o   = pop & (head_id == AUX);
  assign fetch_rdata_o  = instr_rdata_i;
  assign aux_rdata_o    = instr_rdata_i;
  assign fetch_err_o    = instr_err_i;
  assign aux_err_o      = instr_err_i;

  assign busy_o         = (q_count != '0);
  assign protocol_err_o = instr_rvalid_i & q_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_id_q    <= FETCH;
      starve_cnt_q <= '0;
    end else begin
      if (accept) begin
        lock_q <= 1'b0;
      end else if (instr_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel_id;
      end

      if (accept) begin
        if (sel_id == AUX) begin
          starve_cnt_q <= '0;
        end else if (aux_req_i && !starving) begin
          starve_cnt_q <= starve_cnt_q + 1'b1;
        end
      end
    end
  end

  cv32e40p_obi_arb_order_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (sel_id),
    .pop     (pop),
    .head_id (head_id),
    .count   (q_count),
    .empty   (q_empty),
    .full    (q_full)
  );

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// Randomized + directed bench for the instruction OBI arbiter: a queue-based
// reference model predicts arbitration, and a scoreboard checks routed responses.
module tb_cv32e40p_instr_obi_arbiter;

  localparam int MAXO = 2;
  localparam int SL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req_i = 1'b0, aux_req_i = 1'b0;
  logic [31:0] fetch_addr_i = '0, aux_addr_i = '0;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fetch_gnt_o, fetch_rvalid_o, fetch_err_o;
  logic        aux_gnt_o, aux_rvalid_o, aux_err_o;
  logic [31:0] fetch_rdata_o, aux_rdata_o, instr_addr_o;
  logic        instr_req_o, busy_o, protocol_err_o;

  always #5 clk = ~clk;

  cv32e40p_instr_obi_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (SL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_i    (fetch_req_i),
    .fetch_gnt_o    (fetch_gnt_o),
    .fetch_addr_i   (fetch_addr_i),
    .fetch_rvalid_o (fetch_rvalid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_err_o    (fetch_err_o),
    .aux_req_i      (aux_req_i),
    .aux_gnt_o      (aux_gnt_o),
    .aux_addr_i     (aux_addr_i),
    .aux_rvalid_o   (aux_rvalid_o),
    .aux_rdata_o    (aux_rdata_o),
    .aux_err_o      (aux_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rdata_i  (instr_rdata_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o),
    .protocol_err_o (protocol_err_o)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Reference model: outstanding IDs in issue order, fairness count, pending winner.
  rsp_t        sb_q[$];
  int          oq[$];
  int          acc_log[$];
  int          starve;
  bit          lock_v;
  int          lock_id;
  bit          chk_en = 1'b0;
  bit          exp_req, exp_fgnt, exp_agnt, exp_busy, exp_perr;
  logic [31:0] exp_addr;
  bit          last_acc_f, last_acc_a;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    rsp_t r;
    if (chk_en) begin
      check("instr_req", instr_req_o, exp_req);
      if (exp_req) check("instr_addr", instr_addr_o, exp_addr);
      check("fetch_gnt", fetch_gnt_o, exp_fgnt);
      check("aux_gnt", aux_gnt_o, exp_agnt);
      check("busy", busy_o, exp_busy);
      check("protocol_err", protocol_err_o, exp_perr);
      if (fetch_gnt_o) acc_log.push_back(0);
      if (aux_gnt_o) acc_log.push_back(1);
      check("rvalid_count", int'(fetch_rvalid_o) + int'(aux_rvalid_o), (sb_q.size() > 0) ? 1 : 0);
      if ((fetch_rvalid_o || aux_rvalid_o) && sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check("rsp_port", aux_rvalid_o, r.port);
        check("rsp_rdata", aux_rvalid_o ? aux_rdata_o : fetch_rdata_o, r.rdata);
        check("rsp_err", aux_rvalid_o ? aux_err_o : fetch_err_o, r.err);
      end
      sb_q.delete();
    end
  end

  // One bus cycle: drive, predict, let the monitor compare, then advance the model.
  task automatic cycle(input bit freq, input bit areq, input logic [31:0] fa,
                       input logic [31:0] aa, input bit gnt, input bit rv,
                       input logic [31:0] rd, input bit er);
    int   s;
    bit   acc;
    rsp_t r;
    fetch_req_i    = freq;
    aux_req_i      = areq;
    fetch_addr_i   = fa;
    aux_addr_i     = aa;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rd;
    instr_err_i    = er;

    exp_req = (freq || areq) && (oq.size() < MAXO);
    if (lock_v) s = lock_id;
    else if (freq && !(areq && starve == SL)) s = 0;
    else s = 1;
    exp_addr = (s == 1) ? aa : fa;
    acc      = exp_req && gnt;
    exp_fgnt = acc && (s == 0);
    exp_agnt = acc && (s == 1);
    exp_busy = (oq.size() != 0);
    exp_perr = rv && (oq.size() == 0);
    if (rv && oq.size() != 0) begin
      r.port = oq[0]; r.rdata = rd; r.err = er;
      sb_q.push_back(r);
    end

    @(negedge clk);
    #1;
    if (rv && oq.size() != 0) void'(oq.pop_front());
    if (acc) oq.push_back(s);
    if (acc && s == 1) starve = 0;
    else if (acc && areq && starve < SL) starve++;
    if (exp_req && !gnt) begin
      lock_v  = 1'b1;
      lock_id = s;
    end else if (acc) begin
      lock_v = 1'b0;
    end
    last_acc_f = exp_fgnt;
    last_acc_a = exp_agnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en         = 1'b0;
    rst            = 1'b1;
    fetch_req_i    = 1'b0;
    aux_req_i      = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    oq.delete();
    sb_q.delete();
    starve = 0;
    lock_v = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < MAXO + 1 && oq.size() != 0; i++)
      cycle(0, 0, 32'h0, 32'h0, 0, 1, $urandom, $urandom_range(0, 1));
  endtask

  initial begin
    int          exp_ord[10];
    bit          f_pend, a_pend;
    logic [31:0] f_addr, a_addr;
    bit          rv;
    exp_ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    do_reset();
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // Fetch-only stream, response one cycle after each grant.
    cycle(1, 0, 32'h80, 32'h0, 1, 0, 32'h0, 0);
    cycle(1, 0, 32'h84, 32'h0, 1, 1, 32'h1111_0080, 0);
    cycle(1, 0, 32'h88, 32'h0, 1, 1, 32'h1111_0084, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h1111_0088, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // Both requesting continuously: aux wins every fifth accept.
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 10; i++)
      cycle(1, 1, 32'h100 + 32'(4 * i), 32'hA000_0000, 1, oq.size() != 0, $urandom, 0);
    check("starve_order_len", acc_log.size(), 10);
    for (int i = 0; i < 10 && i < acc_log.size(); i++)
      check($sformatf("starve_order[%0d]", i), acc_log[i], exp_ord[i]);
    drain();

    // Aux stalled by gnt low while fetch rises: selection stays on aux.
    do_reset();
    cycle(0, 1, 32'h200, 32'hA000_0040, 0, 0, 32'h0, 0);
    cycle(1, 1, 32'h200, 32'hA000_0040, 0, 0, 32'h0, 0);
    cycle(1, 1, 32'h200, 32'hA000_0040, 0, 0, 32'h0, 0);
    cycle(1, 1, 32'h200, 32'hA000_0040, 1, 0, 32'h0, 0);
    cycle(1, 0, 32'h200, 32'h0, 1, 1, 32'h0000_AAAA, 0);
    drain();

    // F then A outstanding, responses routed in order while req is blocked.
    do_reset();
    cycle(1, 0, 32'h300, 32'h0, 1, 0, 32'h0, 0);
    cycle(0, 1, 32'h0, 32'hA000_0080, 1, 0, 32'h0, 0);
    cycle(1, 1, 32'h304, 32'hA000_0084, 1, 1, 32'hDEAD_BEEF, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_0013, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // Full + accept attempt + rvalid, then count 1 with simultaneous accept/rvalid.
    do_reset();
    cycle(1, 0, 32'h400, 32'h0, 1, 0, 32'h0, 0);
    cycle(0, 1, 32'h0, 32'hA000_0100, 1, 0, 32'h0, 0);
    cycle(1, 0, 32'h404, 32'h0, 1, 1, 32'h0000_0400, 0);
    cycle(1, 0, 32'h404, 32'h0, 1, 1, 32'h0000_0401, 1);
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_0404, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // Stray responses: empty queue, and leftovers from before a reset.
    do_reset();
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h5555_0000, 0);
    cycle(1, 0, 32'h500, 32'h0, 1, 0, 32'h0, 0);
    cycle(0, 1, 32'h0, 32'hA000_0200, 1, 0, 32'h0, 0);
    do_reset();
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h5555_0001, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h5555_0002, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    // Random traffic with OBI-compliant requesters that hold until granted.
    do_reset();
    f_pend = 0; a_pend = 0; f_addr = '0; a_addr = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!f_pend && $urandom_range(0, 1) == 1) begin
        f_pend = 1; f_addr = {$urandom, 2'b00};
      end
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_pend = 1; a_addr = {$urandom, 2'b00};
      end
      if (oq.size() != 0) rv = ($urandom_range(0, 1) == 1);
      else rv = ($urandom_range(0, 39) == 0);
      cycle(f_pend, a_pend, f_addr, a_addr, $urandom_range(0, 3) != 0, rv,
            $urandom, $urandom_range(0, 7) == 0);
      if (last_acc_f) f_pend = 0;
      if (last_acc_a) a_pend = 0;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        f_pend = 0; a_pend = 0;
      end
    end
    drain();
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
